// File: rtl/keypad_scan_if.sv
// keypad_scan_if: keypad code output bundle.
// scan_data holds the last key; valid strobes once per report.
interface keypad_scan_if;
  logic [11:0] scan_data;
  logic        valid;

  modport master (
    output scan_data,
    output valid
  );

  modport slave (
    input scan_data,
    input valid
  );
endinterface

// File: rtl/keypad_scan.sv
// keypad_scan: 4x3 matrix scanner, debounce, one-hot key reports.
// Optional KEYPAD_AUTOREPEAT_EN: re-strobe a held key periodically.
module keypad_scan #(
  parameter int SCAN_DIV      = 1000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 50
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    key_row,
  output logic [2:0]    key_col,
  keypad_scan_if.master kp
);

  localparam int DivW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE, CONFIRM, HELD, RELEASE
  } state_t;

  logic [DivW-1:0] div_q;
  logic [1:0]      col_q;
  logic [11:0]     frame_q;
  logic [11:0]     col_bits;
  logic [11:0]     frame_w;
  logic            sample;
  logic            frame_end;
  logic            f_empty;
  logic            f_single;
  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [3:0]      cnt_inc;
  logic            at_db;
  logic [11:0]     cand_q, cand_d;
  logic [11:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            accept;
  logic            rep_hit;

  // Out-of-range parameters leave no legal configuration.
  if (SCAN_DIV < 2 || DEBOUNCE < 1 || DEBOUNCE > 15 ||
      REPEAT_FRAMES < 1) begin : g_bad_params
  end

  assign sample    = (div_q == DivW'(SCAN_DIV - 1));
  assign frame_end = sample && (col_q == 2'd2);
  assign frame_w   = frame_q | col_bits;
  assign f_empty   = (frame_w == '0);
  assign f_single  = !f_empty &&
                     ((frame_w & (frame_w - 12'd1)) == '0);
  assign cnt_inc   = cnt_q + 4'd1;
  assign at_db     = (cnt_inc >= 4'(DEBOUNCE));

  // Column drive and row-to-code mapping for the driven column.
  always_comb begin
    key_col  = 3'b100;
    col_bits = '0;
    unique case (col_q)
      2'd0: begin
        key_col      = 3'b001;
        col_bits[0]  = key_row[0];
        col_bits[3]  = key_row[1];
        col_bits[6]  = key_row[2];
        col_bits[10] = key_row[3];
      end
      2'd1: begin
        key_col      = 3'b010;
        col_bits[1]  = key_row[0];
        col_bits[4]  = key_row[1];
        col_bits[7]  = key_row[2];
        col_bits[9]  = key_row[3];
      end
      default: begin
        key_col      = 3'b100;
        col_bits[2]  = key_row[0];
        col_bits[5]  = key_row[1];
        col_bits[8]  = key_row[2];
        col_bits[11] = key_row[3];
      end
    endcase
  end

  // Divider, column rotation and frame accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q   <= '0;
      col_q   <= '0;
      frame_q <= '0;
    end else if (sample) begin
      div_q   <= '0;
      col_q   <= (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
      frame_q <= frame_end ? '0 : frame_w;
    end else begin
      div_q   <= div_q + 1'b1;
    end
  end

  // Debounce FSM, stepped once per completed frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    data_d  = data_q;
    valid_d = 1'b0;
    accept  = 1'b0;
    if (frame_end) begin
      unique case (state_q)
        IDLE: begin
          if (f_single) begin
            cand_d = frame_w;
            cnt_d  = 4'd1;
            if (DEBOUNCE == 1) accept  = 1'b1;
            else               state_d = CONFIRM;
          end
        end
        CONFIRM: begin
          if (f_single && frame_w == cand_q) begin
            cnt_d = cnt_inc;
            if (at_db) accept = 1'b1;
          end else if (f_single) begin
            cand_d = frame_w;
            cnt_d  = 4'd1;
          end else begin
            state_d = IDLE;
          end
        end
        HELD: begin
          if (f_empty) begin
            cnt_d   = 4'd1;
            state_d = (DEBOUNCE == 1) ? IDLE : RELEASE;
          end
        end
        default: begin
          if (!f_empty) begin
            state_d = HELD;
          end else if (at_db) begin
            cnt_d   = 4'(DEBOUNCE);
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_inc;
          end
        end
      endcase
      if (accept) begin
        data_d  = frame_w;
        valid_d = 1'b1;
        cnt_d   = 4'(DEBOUNCE);
        state_d = HELD;
      end
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RepW = $clog2(REPEAT_FRAMES + 1);

  logic [RepW-1:0] rep_q, rep_d;

  // Count frames still showing the held code; fire every period.
  always_comb begin
    rep_d   = rep_q;
    rep_hit = 1'b0;
    if (frame_end) begin
      if (state_q == HELD && frame_w == data_q) begin
        if (rep_q == RepW'(REPEAT_FRAMES - 1)) begin
          rep_d   = '0;
          rep_hit = 1'b1;
        end else begin
          rep_d   = rep_q + 1'b1;
        end
      end else begin
        rep_d = '0;
      end
    end
  end

  // Repeat counter register.
  always_ff @(posedge clk) begin
    if (rst) rep_q <= '0;
    else     rep_q <= rep_d;
  end
`else
  assign rep_hit = 1'b0;
`endif

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      data_q  <= data_d;
      valid_q <= valid_d | rep_hit;
    end
  end

  assign kp.scan_data = data_q;
  assign kp.valid     = valid_q;

endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: directed plus random keypad presses.
// Checks every cycle against a frame-level behavioural model.
module tb_keypad_scan;
  localparam int SD = 4;
  localparam int DB = 2;
  localparam int RF = 3;
  localparam int FR = 3 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_row;
  logic [2:0] key_col;
  logic [11:0] held = '0;

  int tests = 0;
  int fails = 0;
  int nvalid = 0;

  keypad_scan_if kif ();

  keypad_scan #(
    .SCAN_DIV(SD),
    .DEBOUNCE(DB),
    .REPEAT_FRAMES(RF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_row(key_row),
    .key_col(key_col),
    .kp(kif.master)
  );

  always #5 clk = ~clk;

  function automatic int key_r(input int b);
    return (b < 9) ? b / 3 : 3;
  endfunction

  function automatic int key_c(input int b);
    if (b < 9) return b % 3;
    if (b == 9) return 1;
    if (b == 10) return 0;
    return 2;
  endfunction

  // Physical keypad: closed key connects its column to its row.
  always_comb begin
    key_row = '0;
    for (int b = 0; b < 12; b++)
      if (held[b] && key_col[key_c(b)])
        key_row[key_r(b)] = 1'b1;
  end

  // Behavioural model: state 0 idle, 1 confirm, 2 held, 3 release.
  int          m_st = 0;
  int          m_cnt = 0;
  int          m_rep = 0;
  logic [11:0] m_cand = '0;
  logic [11:0] m_data = '0;
  logic        m_pend = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_rep = 0;
    m_cand = '0; m_data = '0; m_pend = 1'b0;
  endtask

  task automatic model_frame(input logic [11:0] f);
    int n;
    bit acc;
    n = $countones(f);
    acc = 0;
    m_pend = 1'b0;
    if (m_st == 0) begin
      if (n == 1) begin
        m_cand = f; m_cnt = 1;
        if (m_cnt >= DB) acc = 1; else m_st = 1;
      end
    end else if (m_st == 1) begin
      if (n == 1 && f == m_cand) begin
        m_cnt++;
        if (m_cnt >= DB) acc = 1;
      end else if (n == 1) begin
        m_cand = f; m_cnt = 1;
      end else m_st = 0;
    end else if (m_st == 2) begin
      if (n == 0) begin
        m_cnt = 1; m_rep = 0;
        m_st = (DB == 1) ? 0 : 3;
      end else if (f == m_data) begin
        m_rep++;
`ifdef KEYPAD_AUTOREPEAT_EN
        if (m_rep == RF) begin m_pend = 1'b1; m_rep = 0; end
`endif
      end else m_rep = 0;
    end else begin
      if (n == 0) begin
        m_cnt++;
        if (m_cnt >= DB) begin m_st = 0; m_cnt = DB; end
      end else begin m_st = 2; m_rep = 0; end
    end
    if (acc) begin
      m_data = f; m_pend = 1'b1; m_st = 2; m_rep = 0;
    end
  endtask

  // One frame (or a prefix of one) with a fixed set of closed keys.
  task automatic run_frame(input logic [11:0] mask, input int len);
    held = mask;
    for (int k = 0; k < len; k++) begin
      @(negedge clk);
      chk("key_col", 32'(key_col), 32'(3'b001) << (k / SD));
      chk("valid", 32'(kif.valid), (k == 0) ? 32'(m_pend) : 0);
      chk("scan_data", 32'(kif.scan_data), 32'(m_data));
      if (kif.valid) nvalid++;
      @(posedge clk);
      #1;
    end
    if (len == FR) model_frame(mask);
  endtask

  task automatic frames(input logic [11:0] mask, input int n);
    for (int i = 0; i < n; i++) run_frame(mask, FR);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    for (int i = 0; i < n - 1; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_key_col", 32'(key_col), 32'h1);
      chk("rst_valid", 32'(kif.valid), 32'h0);
      chk("rst_scan_data", 32'(kif.scan_data), 32'h0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  int v0;
  int expn;

  initial begin
    do_reset(3);
    frames(12'h000, 2);

    v0 = nvalid;
    frames(12'h010, 4);
    frames(12'h000, 3);
    chk("key5_count", nvalid - v0, 1);
    chk("key5_code", 32'(kif.scan_data), 32'h010);

    frames(12'h400, 3); frames(12'h000, 3);
    chk("star_code", 32'(kif.scan_data), 32'h400);
    frames(12'h200, 3); frames(12'h000, 3);
    chk("zero_code", 32'(kif.scan_data), 32'h200);
    frames(12'h800, 3); frames(12'h000, 3);
    chk("hash_code", 32'(kif.scan_data), 32'h800);

    v0 = nvalid;
    frames(12'h004, 1); frames(12'h000, 2);
    frames(12'h003, 5); frames(12'h000, 2);
    chk("bounce_multi_count", nvalid - v0, 0);

    v0 = nvalid;
    frames(12'h040, 3); frames(12'h000, 1);
    frames(12'h040, 2);
    chk("release_glitch_count", nvalid - v0, 1);
    frames(12'h000, 2); frames(12'h040, 3);
    frames(12'h000, 3);
    chk("repress_count", nvalid - v0, 2);
    chk("key7_code", 32'(kif.scan_data), 32'h040);

    v0 = nvalid;
    frames(12'h000, 1);
    frames(12'h100, 10);
`ifdef KEYPAD_AUTOREPEAT_EN
    expn = 3;
`else
    expn = 1;
`endif
    chk("hold9_count", nvalid - v0, expn);
    run_frame(12'h100, 5);
    do_reset(2);
    v0 = nvalid;
    frames(12'h100, 4);
    chk("key9_after_rst", nvalid - v0, 1);
    chk("key9_code", 32'(kif.scan_data), 32'h100);
    frames(12'h000, 3);

    for (int r = 0; r < 40; r++) begin
      int sel, a, b;
      logic [11:0] m;
      sel = $urandom_range(0, 9);
      a = $urandom_range(0, 11);
      b = (a + 1 + $urandom_range(0, 10)) % 12;
      m = '0;
      if (sel >= 2) m[a] = 1'b1;
      if (sel >= 7) m[b] = 1'b1;
      if (sel == 9) m[$urandom_range(0, 11)] = 1'b1;
      frames(m, $urandom_range(1, 5));
    end
    frames(12'h000, 3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
